pipe_stage_reg: RTL

- Parametrised pipeline-stage register for the 5-stage MIPS datapath; successor to the fixed 32-bit enable/clear stage registers.
- Carries an arbitrary-width payload, e.g. {PC+4, instruction} = 64 bits for IF/ID.
- Uses a valid/ready handshake with a 2-entry skid buffer, so a stall never causes a combinational ready path back to the previous stage.
- Adds a synchronous flush that inserts a configurable bubble value, plus a saturating stall-cycle counter for performance debug.

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/reg_en_clr.sv | 23 ++
 rtl/pipe_stage_reg.sv | 108 ++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline-stage registers.
package pipe_pkg;

  // Occupancy of a stage register, doubles as the encoded occupancy output
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_e;

  // Per-slot write control: clr wins over en
  typedef struct packed {
    logic en;
    logic clr;
  } slot_ctl_t;

  localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

  // Payload widths of the four inter-stage registers
  localparam int IF_ID_W  = 64;              // {pc+4, instr}
  localparam int ID_EX_W  = 4*32 + 3*5 + 9;  // {pc+4, rs_val, rt_val, imm, rs, rt, rd, ctrl}
  localparam int EX_MEM_W = 2*32 + 5 + 5;    // {alu_res, rt_val, dst, ctrl}
  localparam int MEM_WB_W = 2*32 + 5 + 2;    // {mem_data, alu_res, dst, ctrl}

endpackage

// File: rtl/reg_en_clr.sv
// Data register with async active-low reset, load enable and sync clear.
module reg_en_clr
  import pipe_pkg::*;
#(
  parameter int                DATA_W  = 64,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  // Clear takes priority over a load in the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      q <= RST_VAL;
    else if (clr)  q <= RST_VAL;
    else if (en)   q <= d;
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake and a 2-entry skid
// buffer. Slot 0 is the head (drives out_data), slot 1 the skid slot.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = 64,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}},
  parameter int                CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  occ_e                   state_q, state_d;
  logic                   in_ready_q;
  logic                   accept, drain;
  slot_ctl_t [1:0]        ctl;
  logic [1:0][DATA_W-1:0] slot_d, slot_q;
  logic [CNT_W-1:0]       stall_q;

  assign accept    = in_valid & in_ready_q;
  assign drain     = out_valid & out_ready;
  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = in_ready_q;
  assign out_data  = slot_q[0];
  assign occupancy = state_q;
  assign stall_cnt = stall_q;

  // Next occupancy and slot writes; flush overrides any handshake
  always_comb begin
    state_d   = state_q;
    ctl       = '0;
    slot_d[0] = in_data;
    slot_d[1] = in_data;
    if (flush) begin
      state_d    = ST_EMPTY;
      ctl[0].clr = 1'b1;
      ctl[1].clr = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) begin
          state_d   = ST_ONE;
          ctl[0].en = 1'b1;
        end
        ST_ONE: begin
          if (accept && drain) begin
            ctl[0].en = 1'b1;
          end else if (accept) begin
            state_d   = ST_FULL;
            ctl[1].en = 1'b1;
          end else if (drain) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: if (drain) begin
          state_d   = ST_ONE;
          ctl[0].en = 1'b1;
          slot_d[0] = slot_q[1];
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Main and skid payload slots
  for (genvar i = 0; i < 2; i++) begin : g_slot
    reg_en_clr #(
      .DATA_W  (DATA_W),
      .RST_VAL (BUBBLE_VAL)
    ) u_slot (
      .clk (clk),
      .rst (rst),
      .en  (ctl[i].en),
      .clr (ctl[i].clr),
      .d   (slot_d[i]),
      .q   (slot_q[i])
    );
  end

  // Occupancy state and registered ready (no comb path from out_ready)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_FULL);
    end
  end

  // Saturating count of back-pressured cycles; flush does not clear it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                          stall_q <= '0;
    else if (out_valid && !out_ready && stall_q != CNT_MAX) stall_q <= stall_q + CNT_W'(1);
  end

endmodule
